// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I MEM stage: widths, memop codes and FSM states.
package mem_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LBU  = 4'd4;
    localparam logic [3:0] MEMOP_LHU  = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage and data memory.
interface mem_access_stage_if
    import mem_pkg::*;
#(
    parameter int AW = mem_pkg::ADDR_WIDTH,
    parameter int DW = mem_pkg::DATA_WIDTH
) ();
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_sel_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane logic: store enables/replication, misalignment detect, load extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]            req_op_i,
    input  logic [1:0]            req_off_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [3:0]            ld_op_i,
    input  logic [1:0]            ld_off_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  is_mem_o,
    output logic                  is_store_o,
    output logic                  misalign_o,
    output logic [3:0]            sel_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Request side: classify the op, pick byte enables and replicate store data
    always_comb begin
        is_mem_o   = 1'b0;
        is_store_o = 1'b0;
        misalign_o = 1'b0;
        sel_o      = 4'b0000;
        wdata_o    = 32'h0000_0000;
        case (req_op_i)
            MEMOP_LB, MEMOP_LBU: begin
                is_mem_o = 1'b1;
                sel_o    = 4'b0001 << req_off_i;
            end
            MEMOP_SB: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
                sel_o      = 4'b0001 << req_off_i;
                wdata_o    = {4{store_data_i[7:0]}};
            end
            MEMOP_LH, MEMOP_LHU: begin
                is_mem_o   = 1'b1;
                misalign_o = req_off_i[0];
                sel_o      = req_off_i[1] ? 4'b1100 : 4'b0011;
            end
            MEMOP_SH: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
                misalign_o = req_off_i[0];
                sel_o      = req_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{store_data_i[15:0]}};
            end
            MEMOP_LW: begin
                is_mem_o   = 1'b1;
                misalign_o = (req_off_i != 2'b00);
                sel_o      = 4'b1111;
            end
            MEMOP_SW: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
                misalign_o = (req_off_i != 2'b00);
                sel_o      = 4'b1111;
                wdata_o    = store_data_i;
            end
            default: begin
                is_mem_o = 1'b0;
            end
        endcase
    end

    // Load side: pull the addressed lane out of the word and extend it
    always_comb begin
        byte_s    = rdata_i[{ld_off_i, 3'b000} +: 8];
        half_s    = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = 32'h0000_0000;
        case (ld_op_i)
            MEMOP_LB:  ld_data_o = {{24{byte_s[7]}}, byte_s};
            MEMOP_LBU: ld_data_o = {24'h00_0000, byte_s};
            MEMOP_LH:  ld_data_o = {{16{half_s[15]}}, half_s};
            MEMOP_LHU: ld_data_o = {16'h0000, half_s};
            MEMOP_LW:  ld_data_o = rdata_i;
            default:   ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: issues loads/stores on the req/ack port, formats load data,
// registers the write-back port and stalls upstream while an access is in flight.
module mem_access_stage #(
    parameter int ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = mem_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mem_pkg::REG_ADDR_WIDTH,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid_i,
    input  logic                      ex_wreg_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wd_i,
    input  logic [DATA_WIDTH-1:0]     ex_wdata_i,
    input  logic [3:0]                ex_memop_i,
    input  logic [ADDR_WIDTH-1:0]     ex_mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     ex_store_data_i,
    output logic                      stall_req_o,
    mem_access_stage_if.master        mem_if,
    output logic                      wb_we_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_waddr_o,
    output logic [DATA_WIDTH-1:0]     wb_wdata_o,
    output logic                      exc_misalign_o,
    output logic                      exc_bus_o
);
    import mem_pkg::*;

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]                mem_sel_q, mem_sel_d, op_q, op_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d, wb_waddr_q, wb_waddr_d;
    logic                      wb_we_q, wb_we_d, exc_mis_q, exc_mis_d, exc_bus_q, exc_bus_d;
    logic [DATA_WIDTH-1:0]     wb_wdata_q, wb_wdata_d;
    logic                      stall_s, is_mem_s, is_store_s, misalign_s;
    logic [3:0]                sel_s;
    logic [DATA_WIDTH-1:0]     wdata_s, ld_data_s;

    mem_lane_align u_lane (
        .req_op_i     (ex_memop_i),
        .req_off_i    (ex_mem_addr_i[1:0]),
        .store_data_i (ex_store_data_i),
        .ld_op_i      (op_q),
        .ld_off_i     (off_q),
        .rdata_i      (mem_if.mem_rdata_i),
        .is_mem_o     (is_mem_s),
        .is_store_o   (is_store_s),
        .misalign_o   (misalign_s),
        .sel_o        (sel_s),
        .wdata_o      (wdata_s),
        .ld_data_o    (ld_data_s)
    );

    // Next-state, stall and output-register logic for the IDLE/WAIT access FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_d        = rd_q;
        wb_we_d     = 1'b0;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        exc_mis_d   = 1'b0;
        exc_bus_d   = 1'b0;
        stall_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i && is_mem_s) begin
                    if (misalign_s) begin
                        exc_mis_d = 1'b1;
                    end else begin
                        stall_s     = 1'b1;
                        state_d     = ST_WAIT;
                        cnt_d       = {CNT_W{1'b0}};
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store_s;
                        mem_addr_d  = {ex_mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = wdata_s;
                        mem_sel_d   = sel_s;
                        op_d        = ex_memop_i;
                        off_d       = ex_mem_addr_i[1:0];
                        rd_d        = ex_wd_i;
                    end
                end else begin
                    wb_we_d    = ex_valid_i & ex_wreg_i & (ex_wd_i != {REG_ADDR_WIDTH{1'b0}});
                    wb_waddr_d = ex_wd_i;
                    wb_wdata_d = ex_wdata_i;
                end
            end
            ST_WAIT: begin
                // Releasing stall on the last WAIT cycle lets upstream retire the op with the abort
                stall_s = !mem_if.mem_ack_i && (cnt_q != CNT_LAST);
                if (mem_if.mem_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d     = ST_IDLE;
                    cnt_d       = {CNT_W{1'b0}};
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {ADDR_WIDTH{1'b0}};
                    mem_wdata_d = {DATA_WIDTH{1'b0}};
                    mem_sel_d   = 4'b0000;
                    exc_bus_d   = !mem_if.mem_ack_i;
                    if (mem_if.mem_ack_i && !mem_we_q) begin
                        wb_we_d    = (rd_q != {REG_ADDR_WIDTH{1'b0}});
                        wb_waddr_d = rd_q;
                        wb_wdata_d = ld_data_s;
                    end else begin
                        wb_we_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            mem_sel_q   <= 4'b0000;
            op_q        <= MEMOP_NONE;
            off_q       <= 2'b00;
            rd_q        <= {REG_ADDR_WIDTH{1'b0}};
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= {REG_ADDR_WIDTH{1'b0}};
            wb_wdata_q  <= {DATA_WIDTH{1'b0}};
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            exc_mis_q   <= exc_mis_d;
            exc_bus_q   <= exc_bus_d;
        end
    end

    assign stall_req_o        = stall_s;
    assign mem_if.mem_req_o   = mem_req_q;
    assign mem_if.mem_we_o    = mem_we_q;
    assign mem_if.mem_addr_o  = mem_addr_q;
    assign mem_if.mem_wdata_o = mem_wdata_q;
    assign mem_if.mem_sel_o   = mem_sel_q;
    assign wb_we_o            = wb_we_q;
    assign wb_waddr_o         = wb_waddr_q;
    assign wb_wdata_o         = wb_wdata_q;
    assign exc_misalign_o     = exc_mis_q;
    assign exc_bus_o          = exc_bus_q;

endmodule
